sample_rom_streamer: RTL and testbench

SAMPLE_ROM_STREAMER -- requirements
Module: sample_rom_streamer

---
 rtl/sample_rom_streamer.sv | 150 +++++++++++++++
 tb/tb_sample_rom_streamer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_rom_streamer.sv
// Multi-channel sample ROM streamer: NUM_CH parallel sample memories read in lockstep
// and streamed as one vector per cycle over a valid/ready interface, one-shot or looping.
module sample_rom_streamer #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 128,
  parameter int NUM_CH = 4,
  parameter int AW     = $clog2(DEPTH),
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     loop_mode,
  input  logic                     abort,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [AW-1:0]            out_index,
  output logic                     busy,
  output logic                     frame_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM
  } state_e;

  state_e          state_q, state_d;
  logic            loop_q, loop_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   index_q, index_d;
  logic            frame_done_q, frame_done_d;

  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            xfer;
  logic            wr_ok;

  // An abort in the same cycle as a handshake cancels it: no vector is consumed.
  assign xfer  = valid_q & out_ready & ~abort;
  assign wr_ok = wr_en & ~rst & (state_q == S_IDLE);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    loop_d       = loop_q;
    valid_d      = valid_q;
    index_d      = index_q;
    frame_done_d = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = index_q + AW'(1);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          loop_d  = loop_mode;
          rd_en   = 1'b1;
          rd_addr = '0;
          index_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = S_STREAM;
          valid_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (xfer) begin
          if (index_q == AW'(DEPTH - 1)) begin
            frame_done_d = 1'b1;
            if (!loop_q) begin
              state_d = S_IDLE;
              valid_d = 1'b0;
            end else begin
              rd_en   = 1'b1;
              index_d = index_q + AW'(1);
            end
          end else begin
            rd_en   = 1'b1;
            index_d = index_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      loop_q       <= 1'b0;
      valid_q      <= 1'b0;
      index_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      loop_q       <= loop_d;
      valid_q      <= valid_d;
      index_q      <= index_d;
      frame_done_q <= frame_done_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] data_q;

    // NOTE: the sample memory has no reset; contents survive rst and only wr_en changes them.
    always_ff @(posedge clk) begin
      if (wr_ok && (wr_ch == CH_W'(c))) begin
        mem[wr_addr] <= wr_data;
      end
    end

    // The read register is the output register; it only advances on an issued read,
    // which keeps the vector stable under backpressure. A same-edge write is not seen.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
      end else if (rd_en) begin
        data_q <= mem[rd_addr];
      end
    end

    assign out_data[c*DATA_W +: DATA_W] = data_q;
  end

  assign out_valid  = valid_q;
  assign out_index  = index_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sample_rom_streamer.sv
// Directed bench for sample_rom_streamer (DEPTH=4, NUM_CH=2, DATA_W=26), plus a
// 3-channel instance used to exercise out-of-range wr_ch.
module tb_sample_rom_streamer;

  localparam int DW = 26;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst, start, loop_mode, abort, wr_en, out_ready;
  logic [1:0]           wr_ch3;
  logic [1:0]           wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 wr_en_main;

  logic          out_valid, busy, frame_done;
  logic [2*DW-1:0] out_data;
  logic [1:0]    out_index;

  logic          out_valid3, busy3, frame_done3;
  logic [3*DW-1:0] out_data3;
  logic [1:0]    out_index3;

  int total = 0;
  int bad   = 0;

  logic signed [DW-1:0] m0 [DP];
  logic signed [DW-1:0] m1 [DP];

  always #5 clk = ~clk;

  // The 2-channel DUT cannot encode wr_ch >= 2, so only the 3-channel DUT sees those writes.
  assign wr_en_main = wr_en & (wr_ch3 < 2'd2);

  sample_rom_streamer #(.DATA_W(DW), .DEPTH(DP), .NUM_CH(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .loop_mode(loop_mode), .abort(abort),
    .wr_en(wr_en_main), .wr_ch(wr_ch3[0]), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .busy(busy), .frame_done(frame_done)
  );

  sample_rom_streamer #(.DATA_W(DW), .DEPTH(DP), .NUM_CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .loop_mode(loop_mode), .abort(abort),
    .wr_en(wr_en), .wr_ch(wr_ch3), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_ready(out_ready), .out_valid(out_valid3), .out_data(out_data3),
    .out_index(out_index3), .busy(busy3), .frame_done(frame_done3)
  );

  function automatic logic [2*DW-1:0] expv(input int i);
    return {m1[i], m0[i]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] addr, input logic signed [DW-1:0] data);
    wr_en = 1'b1; wr_ch3 = ch; wr_addr = addr; wr_data = data;
    step();
    wr_en = 1'b0; wr_ch3 = 2'd0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && busy; k++) step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: busy=%b required 0", name, busy);
    end
  endtask

  // One-shot frame with out_ready=1; optionally a write issued in the start cycle.
  task automatic run_frame_check(input string name, input bit with_wr, input logic [1:0] wch,
                                 input logic [1:0] waddr, input logic signed [DW-1:0] wdata);
    bit pend = 1'b0;
    loop_mode = 1'b0; out_ready = 1'b1; start = 1'b1;
    if (with_wr) begin
      wr_en = 1'b1; wr_ch3 = wch; wr_addr = waddr; wr_data = wdata;
      if (waddr != 2'd0) begin
        if (wch == 2'd0) m0[waddr] = wdata; else m1[waddr] = wdata;
      end else pend = 1'b1;
    end
    step();
    start = 1'b0; wr_en = 1'b0; wr_ch3 = 2'd0;
    total++;
    if ({out_valid, busy} !== 2'b01) begin
      bad++;
      $display("FAIL %s_fetch: valid,busy=%b required 01", name, {out_valid, busy});
    end
    step();
    for (int k = 0; k < DP; k++) begin
      total++;
      if ({out_valid, out_index, out_data} !== {1'b1, 2'(k), expv(k)}) begin
        bad++;
        $display("FAIL %s_vec%0d: valid=%b idx=%0d data=%h required 1 %0d %h",
                 name, k, out_valid, out_index, out_data, k, expv(k));
      end
      total++;
      if (out_data3[2*DW-1:0] !== expv(k)) begin
        bad++;
        $display("FAIL %s_vec3_%0d: data=%h required %h", name, k, out_data3[2*DW-1:0], expv(k));
      end
      if (pend && k == 0) begin
        if (wch == 2'd0) m0[0] = wdata; else m1[0] = wdata;
      end
      step();
    end
    total++;
    if ({frame_done, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL %s_end: done,valid,busy=%b required 100", name, {frame_done, out_valid, busy});
    end
    step();
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_pulse: frame_done=%b required 0", name, frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; wr_en = 1'b0; loop_mode = 1'b1;
    out_ready = 1'b0; wr_ch3 = 2'd0; wr_addr = 2'd0; wr_data = '0;
    step(); step();
    total++;
    if ({out_valid, out_data, out_index, busy, frame_done} !== '0) begin
      bad++;
      $display("FAIL reset: valid=%b data=%h idx=%0d busy=%b done=%b required all 0",
               out_valid, out_data, out_index, busy, frame_done);
    end
    rst = 1'b0; start = 1'b0; loop_mode = 1'b0;
    step();
  endtask

  task automatic test_load();
    m0[0] = -26'sd3696;  m0[1] = 26'sd7920;   m0[2] = 26'sd9044; m0[3] = 26'sd10583;
    m1[0] = -26'sd11888; m1[1] = -26'sd2203;  m1[2] = 26'sd1067; m1[3] = 26'sd4716;
    for (int i = 0; i < DP; i++) begin
      wr(2'd0, 2'(i), m0[i]);
      wr(2'd1, 2'(i), m1[i]);
    end
  endtask

  task automatic test_stall();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int got = 0;
    logic v;
    logic [1:0] i;
    logic [2*DW-1:0] d;
    loop_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 20 && got < DP; k++) begin
      out_ready = pat[k % 4];
      v = out_valid; i = out_index; d = out_data;
      step();
      if (v && pat[k % 4]) begin
        total++;
        if ({i, d} !== {2'(got), expv(got)}) begin
          bad++;
          $display("FAIL stall_xfer%0d: idx=%0d data=%h required %0d %h", got, i, d, got, expv(got));
        end
        got++;
      end else if (v) begin
        total++;
        if ({out_valid, out_index, out_data} !== {1'b1, i, d}) begin
          bad++;
          $display("FAIL stall_hold: valid=%b idx=%0d data=%h required 1 %0d %h",
                   out_valid, out_index, out_data, i, d);
        end
      end
    end
    total++;
    if ({got, out_valid, busy} !== {DP, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL stall_count: transfers=%0d valid=%b busy=%b required %0d 0 0", got, out_valid, busy, DP);
    end
    step();
  endtask

  task automatic test_loop();
    int fd = 0;
    loop_mode = 1'b1; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; loop_mode = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({out_valid, out_index, out_data} !== {1'b1, 2'(k % 4), expv(k % 4)}) begin
        bad++;
        $display("FAIL loop_vec%0d: valid=%b idx=%0d data=%h required 1 %0d %h",
                 k, out_valid, out_index, out_data, k % 4, expv(k % 4));
      end
      step();
      fd += int'(frame_done);
    end
    total++;
    if (fd !== 2) begin
      bad++;
      $display("FAIL loop_frame_done: pulses=%0d required 2", fd);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if ({out_valid, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL loop_abort: valid,busy,done=%b required 000", {out_valid, busy, frame_done});
    end
  endtask

  task automatic test_abort();
    loop_mode = 1'b0; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    total++;
    if ({out_valid, out_index} !== 3'b110) begin
      bad++;
      $display("FAIL abort_pre: valid=%b idx=%0d required 1 2", out_valid, out_index);
    end
    abort = 1'b1; start = 1'b1;
    step();
    total++;
    if ({out_valid, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle: valid,busy,done=%b required 000", {out_valid, busy, frame_done});
    end
    abort = 1'b0; start = 1'b0;
    step();
    total++;
    if ({busy, frame_done} !== 2'b00) begin
      bad++;
      $display("FAIL abort_after: busy,done=%b required 00", {busy, frame_done});
    end
    run_frame_check("abort_restart", 1'b0, 2'd0, 2'd0, '0);
  endtask

  task automatic test_write_busy();
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    wr_en = 1'b1; wr_ch3 = 2'd0; wr_addr = 2'd1; wr_data = 26'sd123;
    step();
    wr_en = 1'b0;
    drain("wr_busy");
    step();
    run_frame_check("wr_busy_frame", 1'b0, 2'd0, 2'd0, '0);
  endtask

  task automatic test_ignore_ch();
    wr(2'd3, 2'd2, 26'sd777);
    run_frame_check("ch3_ignored", 1'b0, 2'd0, 2'd0, '0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({out_valid, out_data, out_index, busy, frame_done} !== '0) begin
      bad++;
      $display("FAIL reset_mid: valid=%b data=%h idx=%0d busy=%b done=%b required all 0",
               out_valid, out_data, out_index, busy, frame_done);
    end
    step();
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_done: frame_done=%b required 0", frame_done);
    end
    run_frame_check("reset_replay", 1'b0, 2'd0, 2'd0, '0);
  endtask

  task automatic test_same_cycle_write();
    run_frame_check("wr_start_a0", 1'b1, 2'd0, 2'd0, 26'sd555);
    run_frame_check("wr_start_a2", 1'b1, 2'd1, 2'd2, -26'sd1);
    run_frame_check("wr_start_after", 1'b0, 2'd0, 2'd0, '0);
  endtask

  initial begin
    test_reset();
    test_load();
    run_frame_check("one_shot", 1'b0, 2'd0, 2'd0, '0);
    test_stall();
    test_loop();
    test_abort();
    test_write_busy();
    test_ignore_ch();
    test_reset_mid();
    test_same_cycle_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
